// File: rtl/collision_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// collision_scheduler_pkg
// Shared types and default geometry for the collision scheduler slice:
//   - default coordinate widths, sprite/pipe sizes and ground line
//   - coord_x_t / coord_y_t screen coordinate types (default widths)
//   - scan_state_t, the scheduler FSM state encoding
// -----------------------------------------------------------------------------
package collision_scheduler_pkg;

   localparam int WIDTH_DEF     = 10;
   localparam int HEIGHT_DEF    = 10;
   localparam int NUM_PIPES_DEF = 4;
   localparam int BIRD_W_DEF    = 16;
   localparam int BIRD_H_DEF    = 16;
   localparam int PIPE_W_DEF    = 32;
   localparam int GAP_H_DEF     = 96;
   localparam int GROUND_Y_DEF  = 440;

   typedef logic [WIDTH_DEF-1:0]  coord_x_t;
   typedef logic [HEIGHT_DEF-1:0] coord_y_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2
   } scan_state_t;

endpackage

// File: rtl/collision_scheduler_if.sv
// -----------------------------------------------------------------------------
// collision_scheduler_if
// Bundle between the game logic (master: pipe generator, bird physics and
// game-state FSM) and the collision scheduler (slave).
//   master drives : enable, frame_tick, clear_hit, bird_x, bird_y,
//                   pipe_x, pipe_y, pipe_valid
//   slave drives  : scan_busy, scan_done, hit, hit_idx, overrun
// Pipe i occupies pipe_x[i*WIDTH +: WIDTH] / pipe_y[i*HEIGHT +: HEIGHT].
// -----------------------------------------------------------------------------
interface collision_scheduler_if
   import collision_scheduler_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int HEIGHT    = HEIGHT_DEF,
   parameter int NUM_PIPES = NUM_PIPES_DEF
);
   localparam int IDX_W = $clog2(NUM_PIPES + 1);

   logic                          enable;
   logic                          frame_tick;
   logic                          clear_hit;
   logic [WIDTH-1:0]              bird_x;
   logic [HEIGHT-1:0]             bird_y;
   logic [NUM_PIPES*WIDTH-1:0]    pipe_x;
   logic [NUM_PIPES*HEIGHT-1:0]   pipe_y;
   logic [NUM_PIPES-1:0]          pipe_valid;
   logic                          scan_busy;
   logic                          scan_done;
   logic                          hit;
   logic [IDX_W-1:0]              hit_idx;
   logic                          overrun;

   modport master (
      output enable, frame_tick, clear_hit, bird_x, bird_y, pipe_x, pipe_y, pipe_valid,
      input  scan_busy, scan_done, hit, hit_idx, overrun
   );

   modport slave (
      input  enable, frame_tick, clear_hit, bird_x, bird_y, pipe_x, pipe_y, pipe_valid,
      output scan_busy, scan_done, hit, hit_idx, overrun
   );

endinterface

// File: rtl/collision_scheduler_pipe_hit_check.sv
// -----------------------------------------------------------------------------
// collision_scheduler_pipe_hit_check
// Purely combinational bird-vs-pipe overlap test, shared across all pipes by
// the scheduler.
//   i_valid    : pipe is on screen (an invalid pipe never hits)
//   i_bird_x/y : bird left / top edge
//   i_pipe_x/y : pipe left edge / gap top
//   o_hit      : bird overlaps the pipe horizontally and is outside the gap
// Sums are widened (x by 1 bit, y by 2 bits) so sprites near the screen edge
// never wrap around.
// -----------------------------------------------------------------------------
module collision_scheduler_pipe_hit_check
   import collision_scheduler_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF,
   parameter int BIRD_W = BIRD_W_DEF,
   parameter int BIRD_H = BIRD_H_DEF,
   parameter int PIPE_W = PIPE_W_DEF,
   parameter int GAP_H  = GAP_H_DEF
)
(
   input  logic              i_valid,
   input  logic [WIDTH-1:0]  i_bird_x,
   input  logic [HEIGHT-1:0] i_bird_y,
   input  logic [WIDTH-1:0]  i_pipe_x,
   input  logic [HEIGHT-1:0] i_pipe_y,
   output logic              o_hit
);
   localparam logic [WIDTH:0]  C_BW = (WIDTH+1)'(BIRD_W);
   localparam logic [WIDTH:0]  C_PW = (WIDTH+1)'(PIPE_W);
   localparam logic [HEIGHT+1:0] C_BH = (HEIGHT+2)'(BIRD_H);
   localparam logic [HEIGHT+1:0] C_GH = (HEIGHT+2)'(GAP_H);

   logic [WIDTH:0]    w_bx;
   logic [WIDTH:0]    w_px;
   logic [HEIGHT+1:0] w_by;
   logic [HEIGHT+1:0] w_py;
   logic              w_x_overlap;
   logic              w_outside_gap;

   assign w_bx = {1'b0, i_bird_x};
   assign w_px = {1'b0, i_pipe_x};
   assign w_by = {2'b00, i_bird_y};
   assign w_py = {2'b00, i_pipe_y};

   assign w_x_overlap   = ((w_bx + C_BW) > w_px) && (w_bx < (w_px + C_PW));
   assign w_outside_gap = (w_by < w_py) || ((w_by + C_BH) > (w_py + C_GH));
   assign o_hit         = i_valid && w_x_overlap && w_outside_gap;

endmodule

// File: rtl/collision_scheduler.sv
// -----------------------------------------------------------------------------
// collision_scheduler
// Time-multiplexes one pipe_hit_check comparator across NUM_PIPES pipes once
// per frame. frame_tick snapshots bird/pipe coordinates, one pipe is checked
// per cycle, and results retire through a one-entry stage into a sticky hit.
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : collision_scheduler_if.slave (enable, frame_tick, clear_hit,
//           bird/pipe coordinates in; scan_busy, scan_done, hit, hit_idx,
//           overrun out; all outputs registered)
// Optional feature: define COLLISION_BOUNDS_EN to also flag a hit (hit_idx =
// NUM_PIPES) when the snapshot bird touches the top row or crosses GROUND_Y.
// -----------------------------------------------------------------------------
module collision_scheduler
   import collision_scheduler_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int HEIGHT    = HEIGHT_DEF,
   parameter int NUM_PIPES = NUM_PIPES_DEF,
   parameter int BIRD_W    = BIRD_W_DEF,
   parameter int BIRD_H    = BIRD_H_DEF,
   parameter int PIPE_W    = PIPE_W_DEF,
   parameter int GAP_H     = GAP_H_DEF,
   parameter int GROUND_Y  = GROUND_Y_DEF
)
(
   input  logic                  clk,
   input  logic                  reset,
   collision_scheduler_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_PIPES + 1);
   localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_PIPES - 1);
   localparam logic [IDX_W-1:0]  C_BOUNDS_IDX = IDX_W'(NUM_PIPES);
   localparam logic [HEIGHT+1:0] C_BH = (HEIGHT+2)'(BIRD_H);
   localparam logic [HEIGHT+1:0] C_GY = (HEIGHT+2)'(GROUND_Y);
`ifdef COLLISION_BOUNDS_EN
   localparam bit C_BOUNDS_EN = 1'b1;
`else
   localparam bit C_BOUNDS_EN = 1'b0;
`endif

   scan_state_t                 r_state;
   logic [IDX_W-1:0]            r_idx;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_hit;
   logic [IDX_W-1:0]            r_hit_idx;
   logic                        r_overrun;

   logic [WIDTH-1:0]            r_bx_p0;
   logic [HEIGHT-1:0]           r_by_p0;
   logic [NUM_PIPES*WIDTH-1:0]  r_px_p0;
   logic [NUM_PIPES*HEIGHT-1:0] r_py_p0;
   logic [NUM_PIPES-1:0]        r_pv_p0;

   logic                        r_vld_p1;
   logic                        r_hit_p1;
   logic [IDX_W-1:0]            r_hidx_p1;

   logic [WIDTH-1:0]            w_px;
   logic [HEIGHT-1:0]           w_py;
   logic                        w_pv;
   logic                        w_pipe_hit;
   logic                        w_start;
   logic                        w_bounds;
   logic                        w_retire_hit;
   logic                        w_bounds_hit;
   logic                        w_can_set;

   // Stage p0: snapshot, taken only when a scan starts
   assign w_start = (r_state == IDLE) && bus.frame_tick && bus.enable;

   always_ff @(posedge clk) begin
      if (w_start) begin
         r_bx_p0 <= bus.bird_x;
         r_by_p0 <= bus.bird_y;
         r_px_p0 <= bus.pipe_x;
         r_py_p0 <= bus.pipe_y;
         r_pv_p0 <= bus.pipe_valid;
      end
   end

   always_comb begin
      w_px = '0;
      w_py = '0;
      w_pv = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_px = r_px_p0[i*WIDTH +: WIDTH];
            w_py = r_py_p0[i*HEIGHT +: HEIGHT];
            w_pv = r_pv_p0[i];
         end
      end
   end

   collision_scheduler_pipe_hit_check #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .BIRD_W (BIRD_W),
      .BIRD_H (BIRD_H),
      .PIPE_W (PIPE_W),
      .GAP_H  (GAP_H)
   ) u_hit_check (
      .i_valid  (w_pv),
      .i_bird_x (r_bx_p0),
      .i_bird_y (r_by_p0),
      .i_pipe_x (w_px),
      .i_pipe_y (w_py),
      .o_hit    (w_pipe_hit)
   );

   // Stage p1: one result per SCAN cycle, retired on the following edge
   always_ff @(posedge clk) begin
      if ((r_state == SCAN) && bus.enable) begin
         r_hit_p1  <= w_pipe_hit;
         r_hidx_p1 <= r_idx;
      end
   end

   // Constant-gated so the bounds logic vanishes when the feature is off
   assign w_bounds = C_BOUNDS_EN &&
                     ((r_by_p0 == '0) || (({2'b00, r_by_p0} + C_BH) > C_GY));

   // Dropping enable discards whatever is in flight, so nothing retires then
   assign w_retire_hit = r_vld_p1 && r_hit_p1 && bus.enable;
   assign w_bounds_hit = (r_state == FLUSH) && bus.enable && w_bounds;
   // hit_idx is frozen while hit is set; a same-edge clear lets a new hit in
   assign w_can_set    = !r_hit || bus.clear_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
         r_hit_idx <= '0;
         r_overrun <= 1'b0;
         r_vld_p1  <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_vld_p1 <= 1'b0;

         // Pipe result outranks the bounds check so a pipe hit keeps its index
         if (w_retire_hit && w_can_set) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_hidx_p1;
         end else if (w_bounds_hit && w_can_set) begin
            r_hit     <= 1'b1;
            r_hit_idx <= C_BOUNDS_IDX;
         end else if (bus.clear_hit) begin
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
         end

         if (bus.frame_tick && bus.enable && r_busy) begin
            r_overrun <= 1'b1;
         end else if (bus.clear_hit) begin
            r_overrun <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (!bus.enable) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_vld_p1 <= 1'b1;
                  r_idx    <= r_idx + IDX_W'(1);
                  if (r_idx == C_LAST_IDX) begin
                     r_state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
               r_done  <= bus.enable;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.scan_busy = r_busy;
   assign bus.scan_done = r_done;
   assign bus.hit       = r_hit;
   assign bus.hit_idx   = r_hit_idx;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_collision_scheduler.sv
module tb_collision_scheduler;
   import collision_scheduler_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [2:0] exp_idx;
   logic       exp_hit;

   always #5 clk = ~clk;

   collision_scheduler_if #(.WIDTH(10), .HEIGHT(10), .NUM_PIPES(N)) bus ();

   collision_scheduler #(
      .WIDTH(10), .HEIGHT(10), .NUM_PIPES(N), .BIRD_W(16), .BIRD_H(16),
      .PIPE_W(32), .GAP_H(96), .GROUND_Y(440)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic set_pipe(input int i, input int x, input int y, input bit v);
      bus.pipe_x[i*10 +: 10] = coord_x_t'(x);
      bus.pipe_y[i*10 +: 10] = coord_y_t'(y);
      bus.pipe_valid[i]      = v;
   endtask

   task automatic clear_pipes();
      bus.pipe_x     = '0;
      bus.pipe_y     = '0;
      bus.pipe_valid = '0;
   endtask

   task automatic set_bird(input int x, input int y);
      bus.bird_x = coord_x_t'(x);
      bus.bird_y = coord_y_t'(y);
   endtask

   // Leaves the caller at the falling edge right after the sampling edge
   task automatic start_frame();
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.scan_done && cyc < 20);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      bus.clear_hit = 1'b1;
      @(negedge clk);
      bus.clear_hit = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.scan_busy); end
      checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.scan_done); end
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", bus.hit); end
      checks++; if (bus.hit_idx !== 3'd0) begin errors++; $display("FAIL reset_hit_idx: got %0d want 0", bus.hit_idx); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", bus.overrun); end
      reset = 1'b1;
      bus.enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_hit();
      int cyc;
      clear_pipes();
      set_bird(100, 200);
      set_pipe(0, 90, 150, 1'b1);
      start_frame();
      checks++; if (bus.scan_busy !== 1'b1) begin errors++; $display("FAIL nohit_busy: got %0b want 1", bus.scan_busy); end
      wait_done(cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL nohit_latency: got %0d want 5", cyc); end
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL nohit_hit: got %0b want 0", bus.hit); end
      checks++; if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL nohit_busy_end: got %0b want 0", bus.scan_busy); end
      @(negedge clk);
      checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL nohit_done_pulse: got %0b want 0", bus.scan_done); end
   endtask

   task automatic test_hit_idx();
      int cyc;
      clear_pipes();
      set_bird(100, 100);
      set_pipe(2, 110, 150, 1'b1);
      set_pipe(3, 95, 150, 1'b1);
      start_frame();
      wait_done(cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL hit_latency: got %0d want 5", cyc); end
      checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL hit_set: got %0b want 1", bus.hit); end
      checks++; if (bus.hit_idx !== 3'd2) begin errors++; $display("FAIL hit_idx_first: got %0d want 2", bus.hit_idx); end
      set_pipe(0, 90, 150, 1'b1);
      start_frame();
      wait_done(cyc);
      checks++; if (bus.hit_idx !== 3'd2) begin errors++; $display("FAIL hit_idx_frozen: got %0d want 2", bus.hit_idx); end
   endtask

   task automatic test_overrun();
      int ndone = 0;
      start_frame();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.frame_tick = (k == 1);
         if (bus.scan_done) ndone++;
      end
      bus.frame_tick = 1'b0;
      checks++; if (ndone != 1) begin errors++; $display("FAIL overrun_single_done: got %0d want 1", ndone); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b want 1", bus.overrun); end
      pulse_clear();
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL clear_hit: got %0b want 0", bus.hit); end
      checks++; if (bus.hit_idx !== 3'd0) begin errors++; $display("FAIL clear_hit_idx: got %0d want 0", bus.hit_idx); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun: got %0b want 0", bus.overrun); end
   endtask

   task automatic test_clear_priority();
      int cyc;
      clear_pipes();
      set_bird(100, 100);
      set_pipe(3, 95, 150, 1'b1);
      start_frame();
      wait_done(cyc);
      checks++; if (bus.hit_idx !== 3'd3) begin errors++; $display("FAIL prio_setup_idx: got %0d want 3", bus.hit_idx); end
      set_pipe(2, 110, 150, 1'b1);
      start_frame();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus.clear_hit = 1'b1;
      @(negedge clk);
      bus.clear_hit = 1'b0;
      checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL prio_hit_wins: got %0b want 1", bus.hit); end
      checks++; if (bus.hit_idx !== 3'd2) begin errors++; $display("FAIL prio_idx_updated: got %0d want 2", bus.hit_idx); end
      wait_done(cyc);
      checks++; if (bus.hit_idx !== 3'd2) begin errors++; $display("FAIL prio_idx_after_scan: got %0d want 2", bus.hit_idx); end
      pulse_clear();
   endtask

   task automatic test_reset_mid_scan();
      int cyc;
      clear_pipes();
      set_bird(100, 100);
      set_pipe(0, 90, 150, 1'b1);
      start_frame();
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      checks++; if (bus.hit !== 1'b1 || bus.overrun !== 1'b1 || bus.scan_busy !== 1'b1) begin
         errors++; $display("FAIL midscan_pre: hit=%0b ovr=%0b busy=%0b want 1 1 1", bus.hit, bus.overrun, bus.scan_busy);
      end
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL midscan_busy: got %0b want 0", bus.scan_busy); end
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL midscan_hit: got %0b want 0", bus.hit); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL midscan_overrun: got %0b want 0", bus.overrun); end
      @(negedge clk);
      reset = 1'b1;
      clear_pipes();
      start_frame();
      wait_done(cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL postreset_latency: got %0d want 5", cyc); end
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL postreset_hit: got %0b want 0", bus.hit); end
   endtask

   task automatic test_abort();
      int ndone = 0;
      clear_pipes();
      set_bird(100, 100);
      set_pipe(1, 90, 150, 1'b1);
      start_frame();
      @(negedge clk);
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      checks++; if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", bus.scan_busy); end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         bus.frame_tick = (k == 2);
         if (bus.scan_done) ndone++;
      end
      bus.frame_tick = 1'b0;
      checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL abort_hit: got %0b want 0", bus.hit); end
      checks++; if (bus.overrun !== 1'b0 || bus.scan_busy !== 1'b0) begin
         errors++; $display("FAIL disabled_tick: ovr=%0b busy=%0b want 0 0", bus.overrun, bus.scan_busy);
      end
      bus.enable = 1'b1;
   endtask

   task automatic test_bounds();
      int cyc;
`ifdef COLLISION_BOUNDS_EN
      exp_hit = 1'b1; exp_idx = 3'd4;
`else
      exp_hit = 1'b0; exp_idx = 3'd0;
`endif
      clear_pipes();
      set_bird(100, 430);
      start_frame();
      wait_done(cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL bounds_latency: got %0d want 5", cyc); end
      checks++; if (bus.hit !== exp_hit) begin errors++; $display("FAIL bounds_hit: got %0b want %0b", bus.hit, exp_hit); end
      checks++; if (bus.hit_idx !== exp_idx) begin errors++; $display("FAIL bounds_idx: got %0d want %0d", bus.hit_idx, exp_idx); end
      pulse_clear();
   endtask

   task automatic test_edges();
      int cyc;
      clear_pipes();
      set_bird(100, 100);
      set_pipe(0, 116, 150, 1'b1);
      set_pipe(1, 68, 150, 1'b1);
      set_pipe(2, 69, 150, 1'b1);
      start_frame();
      wait_done(cyc);
      checks++; if (bus.hit !== 1'b1 || bus.hit_idx !== 3'd2) begin
         errors++; $display("FAIL edge_x: hit=%0b idx=%0d want 1 2", bus.hit, bus.hit_idx);
      end
      pulse_clear();
      clear_pipes();
      set_bird(100, 200);
      set_pipe(0, 100, 150, 1'b1);
      set_pipe(1, 100, 120, 1'b1);
      set_pipe(3, 100, 119, 1'b1);
      start_frame();
      wait_done(cyc);
      checks++; if (bus.hit !== 1'b1 || bus.hit_idx !== 3'd3) begin
         errors++; $display("FAIL edge_y: hit=%0b idx=%0d want 1 3", bus.hit, bus.hit_idx);
      end
      pulse_clear();
      clear_pipes();
      set_bird(1010, 100);
      set_pipe(0, 1000, 150, 1'b1);
      start_frame();
      wait_done(cyc);
      checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL edge_nowrap: got %0b want 1", bus.hit); end
      pulse_clear();
   endtask

   initial begin
      bus.enable     = 1'b0;
      bus.frame_tick = 1'b0;
      bus.clear_hit  = 1'b0;
      bus.bird_x     = '0;
      bus.bird_y     = '0;
      clear_pipes();
      test_reset();
      test_no_hit();
      test_hit_idx();
      test_overrun();
      test_clear_priority();
      test_reset_mid_scan();
      test_abort();
      test_bounds();
      test_edges();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
